// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - LCD panel timing generator started by a stable, synchronized PLL lock
// Optional colour-bar source replaces pix_data when LCD_TEST_PATTERN_EN is defined.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 210,
  parameter int H_SYNC   = 20,
  parameter int H_BP     = 26,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 13,
  parameter int LOCK_DLY = 1024
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        locked,
  input  logic [23:0] pix_data,
  output logic        pix_req,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        lcd_hs_n,
  output logic        lcd_vs_n,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam int LW = (LOCK_DLY > 1) ? $clog2(LOCK_DLY) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_DLY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} state_t;

  state_t          state, next_state;
  logic            lock_m, lock_s;
  logic [LW-1:0]   lock_cnt;
  logic            run_go;
  logic [10:0]     h_cnt;
  logic [9:0]      v_cnt;
  logic            h_act, v_act, hs_t, vs_t;
  logic            de_d, hs_d, vs_d;
  logic [23:0]     rgb_src;

  // locked comes from the PLL domain; nothing downstream sees it unsynchronized
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= locked;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    run_go     = 1'b0;
    case (state)
      S_IDLE: if (lock_s) next_state = S_WAIT;
      S_WAIT: begin
        if (!lock_s)                    next_state = S_IDLE;
        else if (lock_cnt == LOCK_LAST) next_state = S_RUN;
      end
      S_RUN: begin
        run_go = lock_s;
        if (!lock_s) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign running = (state == S_RUN);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)
      lock_cnt <= '0;
    else if (state == S_WAIT && lock_s && lock_cnt != LOCK_LAST)
      lock_cnt <= lock_cnt + LW'(1);
    else
      lock_cnt <= '0;
  end

  // run_go low covers both leaving RUN and lock loss on a wrap cycle
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run_go) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign h_act = (h_cnt < H_ACT);
  assign v_act = (v_cnt < V_ACT);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hs_t        <= 1'b0;
      vs_t        <= 1'b0;
    end else if (!run_go) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hs_t        <= 1'b0;
      vs_t        <= 1'b0;
    end else begin
      pix_req     <= h_act && v_act;
      pix_x       <= (h_act && v_act) ? h_cnt : '0;
      pix_y       <= (h_act && v_act) ? v_cnt : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      hs_t        <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      vs_t        <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    end
  end

  // Middle stage: syncs ride alongside the request so they match the pixel latency
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      de_d <= 1'b0;
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else if (!run_go) begin
      de_d <= 1'b0;
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      de_d <= pix_req;
      hs_d <= hs_t;
      vs_d <= vs_t;
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  logic [10:0] x_d;

  function automatic logic [23:0] bar_rgb(input logic [10:0] x);
    if      (x < 11'd100) return 24'hFFFFFF;
    else if (x < 11'd200) return 24'hFFFF00;
    else if (x < 11'd300) return 24'h00FFFF;
    else if (x < 11'd400) return 24'h00FF00;
    else if (x < 11'd500) return 24'hFF00FF;
    else if (x < 11'd600) return 24'hFF0000;
    else if (x < 11'd700) return 24'h0000FF;
    else                  return 24'h000000;
  endfunction

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)          x_d <= '0;
    else if (!run_go) x_d <= '0;
    else              x_d <= pix_x;
  end

  always_comb begin
    rgb_src = bar_rgb(x_d);
  end
`else
  always_comb begin
    rgb_src = pix_data;
  end
`endif

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lcd_de   <= 1'b0;
      lcd_rgb  <= '0;
      lcd_hs_n <= 1'b1;
      lcd_vs_n <= 1'b1;
    end else if (!run_go) begin
      lcd_de   <= 1'b0;
      lcd_rgb  <= '0;
      lcd_hs_n <= 1'b1;
      lcd_vs_n <= 1'b1;
    end else begin
      lcd_de   <= de_d;
      lcd_rgb  <= de_d ? rgb_src : '0;
      lcd_hs_n <= ~hs_d;
      lcd_vs_n <= ~vs_d;
    end
  end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE 800 (visible pixels per line); H_FP 210; H_SYNC 20; H_BP 26 (line total 1056); V_ACTIVE 480 (visible lines per frame); V_FP 22; V_SYNC 10; V_BP 13 (frame total 525); LOCK_DLY 1024 (stable-lock cycles required before start).
REQ-002 refclk  input  1  pixel clock from the PLL (33.29 MHz nominal); sole clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 locked  input  1  PLL lock indication, asynchronous to refclk.
REQ-005 pix_data  input  24  {R,G,B} pixel for the preceding pix_req, valid one cycle after it.
REQ-006 pix_req  output  1  pixel request strobe.
REQ-007 pix_x / pix_y  output  11 / 10  coordinates of the requested pixel.
REQ-008 frame_start  output  1  one-cycle pulse at request of pixel (0,0).
REQ-009 lcd_hs_n / lcd_vs_n  output  1 / 1  active-low syncs.
REQ-010 lcd_de  output  1  data enable.
REQ-011 lcd_rgb  output  24  pixel to panel; 0 when lcd_de low.
REQ-012 running  output  1  high in state RUN.

Function
REQ-013 locked SHALL pass through a 2-flop synchronizer (lock_s) before any use.
REQ-014 FSM states: IDLE, WAIT, RUN; IDLE->WAIT when lock_s=1; WAIT->RUN when lock counter reaches LOCK_DLY-1 with lock_s=1; WAIT->IDLE when lock_s=0 (counter cleared); RUN->IDLE when lock_s=0.
REQ-015 In RUN, h_cnt SHALL count 0..1055, wrapping to 0; v_cnt SHALL increment on h_cnt wrap, counting 0..524, wrapping to 0; both start at 0 on RUN entry.
REQ-016 Regions: h active 0..799, FP 800..1009, sync 1010..1029, BP 1030..1055; v active 0..479, FP 480..501, sync 502..511, BP 512..524.
REQ-017 pix_req/pix_x/pix_y/frame_start are registered from counters (cycle T); pix_req=1 iff both counters active; pix_x/pix_y = h_cnt/v_cnt when pix_req=1, else 0.
REQ-018 pix_data SHALL be sampled in T+1; lcd_de, lcd_rgb, lcd_hs_n, lcd_vs_n SHALL appear in T+2 (fixed 2-cycle latency, syncs delayed identically).
REQ-019 lcd_hs_n=0 for h sync region; lcd_vs_n=0 for whole lines in v sync region.
REQ-020 Leaving RUN SHALL clear counters and pipeline in the same cycle; outputs go to idle values next cycle; no partial line or frame continues.
REQ-021 Lock loss and counter wrap in the same cycle: lock loss wins.
REQ-022 frame_start SHALL pulse once per frame, coincident with pix_req for (0,0).

Reset
REQ-023 On rst: state IDLE, counters and lock counter 0, synchronizer 0, pix_req=0, pix_x=0, pix_y=0, frame_start=0, lcd_hs_n=1, lcd_vs_n=1, lcd_de=0, lcd_rgb=0, running=0.
REQ-024 Idle values of REQ-023 SHALL hold in IDLE and WAIT.

Configuration
REQ-025 Macro LCD_TEST_PATTERN_EN: when defined, lcd_rgb SHALL be internal colour bars, 100 px wide from x=0: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; pix_data ignored; pix_req still driven.
REQ-026 Without LCD_TEST_PATTERN_EN, lcd_rgb = pix_data per REQ-018; no pattern logic present.

Verification
REQ-027 locked=1 from reset release -> running rises after 2+1+LOCK_DLY cycles (±1); first pix_req with frame_start=1, pix_x=0, pix_y=0.
REQ-028 Run 2 frames -> 1056 cycles between hs_n falls, 20 low; 525*1056 between vs_n falls, 10 lines low; 384000 lcd_de cycles per frame.
REQ-029 pix_data = {pix_x[7:0], pix_y[7:0], 8'h5A} echoed one cycle later -> lcd_rgb matches coordinates exactly 2 cycles after each pix_req.
REQ-030 Drop locked mid-line (h=400, v=100) -> within 4 cycles running=0, lcd_de=0, syncs=1; re-lock -> restart at (0,0) after LOCK_DLY.
REQ-031 locked glitch low for 1 cycle during WAIT -> lock counter restarts; RUN entry delayed by full LOCK_DLY.
REQ-032 With LCD_TEST_PATTERN_EN: pixel x=150 -> FFFF00, x=799 -> 000000, independent of pix_data.
